// File: rtl/mini_multicycle_ctrl.sv
// Multicycle control FSM for the mini-processor: fetch, decode, execute and
// write-back sequencing with sticky overflow and halt reporting.
module mini_multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       Of,
  input  logic       Ng,
  input  logic       Zr,
  input  logic       Eq,
  input  logic       Gt,
  input  logic       Lt,
  input  logic [5:0] OPCODE,
  output logic       PC_w,
  output logic       MEM_w,
  output logic       IR_w,
  output logic       RB_w,
  output logic       AB_w,
  output logic [2:0] ULA_c,
  output logic       M_WREG,
  output logic       M_ULAA,
  output logic       M_ULAB,
  output logic       rst_out,
  output logic       halted,
  output logic       ovf_err,
  output logic [3:0] state
);

  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_SUB  = 6'h02;
  localparam logic [5:0] OP_AND  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_HALT = 6'h3F;

  localparam logic [2:0] ULA_PASS = 3'b000;
  localparam logic [2:0] ULA_ADD  = 3'b001;
  localparam logic [2:0] ULA_SUB  = 3'b010;
  localparam logic [2:0] ULA_AND  = 3'b011;
  localparam logic [2:0] ULA_INC4 = 3'b100;
  localparam logic [2:0] ULA_CMP  = 3'b111;

  typedef enum logic [3:0] {
    S_RST     = 4'd0,
    S_FETCH0  = 4'd1,
    S_FETCH1  = 4'd2,
    S_DECODE  = 4'd3,
    S_EXEC_R  = 4'd4,
    S_EXEC_I  = 4'd5,
    S_WB      = 4'd6,
    S_BEQ_CMP = 4'd7,
    S_BEQ_BR  = 4'd8,
    S_HALT    = 4'd9
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] alu_op_q, alu_op_d;
  logic       is_r_q, is_r_d;
  logic       chk_ovf_q, chk_ovf_d;
  logic       eq_q, eq_d;
  logic       ovf_q, ovf_d;

  // Flags the controller has no use for; kept on the port list for the datapath.
  logic unused_flags;
  assign unused_flags = ^{Ng, Zr, Gt, Lt};

  always_comb begin
    state_d   = state_q;
    alu_op_d  = alu_op_q;
    is_r_d    = is_r_q;
    chk_ovf_d = chk_ovf_q;
    eq_d      = eq_q;
    ovf_d     = ovf_q;
    PC_w      = 1'b0;
    MEM_w     = 1'b0;
    IR_w      = 1'b0;
    RB_w      = 1'b0;
    AB_w      = 1'b0;
    ULA_c     = ULA_PASS;
    M_WREG    = 1'b0;
    M_ULAA    = 1'b0;
    M_ULAB    = 1'b0;
    rst_out   = 1'b0;
    halted    = 1'b0;
    case (state_q)
      S_RST: begin
        rst_out = 1'b1;
        state_d = S_FETCH0;
      end
      S_FETCH0: begin
        ULA_c   = ULA_INC4;
        state_d = S_FETCH1;
      end
      S_FETCH1: begin
        IR_w    = 1'b1;
        PC_w    = 1'b1;
        ULA_c   = ULA_INC4;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        AB_w      = 1'b1;
        alu_op_d  = ULA_PASS;
        is_r_d    = 1'b0;
        chk_ovf_d = 1'b0;
        state_d   = S_FETCH0;
        case (OPCODE)
          OP_ADD:  begin state_d = S_EXEC_R; alu_op_d = ULA_ADD; is_r_d = 1'b1; chk_ovf_d = 1'b1; end
          OP_SUB:  begin state_d = S_EXEC_R; alu_op_d = ULA_SUB; is_r_d = 1'b1; chk_ovf_d = 1'b1; end
          OP_AND:  begin state_d = S_EXEC_R; alu_op_d = ULA_AND; is_r_d = 1'b1; end
          OP_ADDI: begin state_d = S_EXEC_I; alu_op_d = ULA_ADD; chk_ovf_d = 1'b1; end
          OP_BEQ:  state_d = S_BEQ_CMP;
          OP_HALT: state_d = S_HALT;
          default: state_d = S_FETCH0;
        endcase
      end
      S_EXEC_R, S_EXEC_I: begin
        M_ULAA = 1'b1;
        M_ULAB = (state_q == S_EXEC_I);
        ULA_c  = alu_op_q;
        // An overflowing arithmetic op is dropped: no write-back, flag the error.
        if (chk_ovf_q && Of) begin
          ovf_d   = 1'b1;
          state_d = S_FETCH0;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        RB_w    = 1'b1;
        M_WREG  = is_r_q;
        M_ULAA  = 1'b1;
        M_ULAB  = ~is_r_q;
        ULA_c   = alu_op_q;
        state_d = S_FETCH0;
      end
      S_BEQ_CMP: begin
        M_ULAA  = 1'b1;
        ULA_c   = ULA_CMP;
        eq_d    = Eq;
        state_d = S_BEQ_BR;
      end
      S_BEQ_BR: begin
        M_ULAB  = 1'b1;
        ULA_c   = ULA_ADD;
        PC_w    = eq_q;
        state_d = S_FETCH0;
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_RST;
      alu_op_q  <= ULA_PASS;
      is_r_q    <= 1'b0;
      chk_ovf_q <= 1'b0;
      eq_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      alu_op_q  <= alu_op_d;
      is_r_q    <= is_r_d;
      chk_ovf_q <= chk_ovf_d;
      eq_q      <= eq_d;
      ovf_q     <= ovf_d;
    end
  end

  assign ovf_err = ovf_q;
  assign state   = state_q;

endmodule

// File: tb/tb_mini_multicycle_ctrl.sv
// Randomized bench: per instruction, a queue of expected per-cycle output
// vectors is built from the state output table and compared cycle by cycle.
module tb_mini_multicycle_ctrl;

  localparam int ST_RST = 0, ST_F0 = 1, ST_F1 = 2, ST_DEC = 3, ST_EXR = 4,
                 ST_EXI = 5, ST_WB = 6, ST_CMP = 7, ST_BR = 8, ST_HALT = 9;

  logic clk = 1'b0, reset = 1'b1;
  logic Of = 0, Ng = 0, Zr = 0, Eq = 0, Gt = 0, Lt = 0;
  logic [5:0] OPCODE = 6'h00;
  logic PC_w, MEM_w, IR_w, RB_w, AB_w, M_WREG, M_ULAA, M_ULAB, rst_out, halted, ovf_err;
  logic [2:0] ULA_c;
  logic [3:0] state;

  mini_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .Of(Of), .Ng(Ng), .Zr(Zr), .Eq(Eq), .Gt(Gt), .Lt(Lt),
    .OPCODE(OPCODE), .PC_w(PC_w), .MEM_w(MEM_w), .IR_w(IR_w), .RB_w(RB_w), .AB_w(AB_w),
    .ULA_c(ULA_c), .M_WREG(M_WREG), .M_ULAA(M_ULAA), .M_ULAB(M_ULAB),
    .rst_out(rst_out), .halted(halted), .ovf_err(ovf_err), .state(state)
  );

  always #5 clk = ~clk;

  logic [17:0] dut_vec;
  assign dut_vec = {state, PC_w, MEM_w, IR_w, RB_w, AB_w, ULA_c, M_WREG, M_ULAA, M_ULAB,
                    rst_out, halted, ovf_err};

  int n_chk = 0, n_pass = 0;
  bit ovf_m = 0;
  logic [17:0] exp_q[$];
  logic [5:0] cur_op;
  bit cur_of, cur_eq;

  task automatic chk(input string tag, input logic [17:0] got, input logic [17:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [17:0] rec(input int st, input bit pcw, irw, rbw, abw,
                                      input logic [2:0] ula, input bit wr, a, b, rs, h);
    logic [3:0] s4;
    s4 = st[3:0];
    return {s4, pcw, 1'b0, irw, rbw, abw, ula, wr, a, b, rs, h, ovf_m};
  endfunction

  // Expected cycles of one instruction starting at FETCH0.
  task automatic plan(input logic [5:0] op, input bit of, input bit eq);
    logic [2:0] ula;
    cur_op = op; cur_of = of; cur_eq = eq;
    exp_q.push_back(rec(ST_F0, 0, 0, 0, 0, 3'b100, 0, 0, 0, 0, 0));
    exp_q.push_back(rec(ST_F1, 1, 1, 0, 0, 3'b100, 0, 0, 0, 0, 0));
    exp_q.push_back(rec(ST_DEC, 0, 0, 0, 1, 3'b000, 0, 0, 0, 0, 0));
    case (op)
      6'h01, 6'h02, 6'h03: begin
        ula = (op == 6'h01) ? 3'b001 : (op == 6'h02) ? 3'b010 : 3'b011;
        exp_q.push_back(rec(ST_EXR, 0, 0, 0, 0, ula, 0, 1, 0, 0, 0));
        if (of && op != 6'h03) ovf_m = 1;
        else exp_q.push_back(rec(ST_WB, 0, 0, 1, 0, ula, 1, 1, 0, 0, 0));
      end
      6'h08: begin
        exp_q.push_back(rec(ST_EXI, 0, 0, 0, 0, 3'b001, 0, 1, 1, 0, 0));
        if (of) ovf_m = 1;
        else exp_q.push_back(rec(ST_WB, 0, 0, 1, 0, 3'b001, 0, 1, 1, 0, 0));
      end
      6'h04: begin
        exp_q.push_back(rec(ST_CMP, 0, 0, 0, 0, 3'b111, 0, 1, 0, 0, 0));
        exp_q.push_back(rec(ST_BR, eq, 0, 0, 0, 3'b001, 0, 0, 1, 0, 0));
      end
      6'h3F: exp_q.push_back(rec(ST_HALT, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1));
      default: ;
    endcase
  endtask

  // Inputs only carry meaning in the cycle that samples them; elsewhere they are noise.
  task automatic drive(input logic [3:0] st);
    Of = (st == ST_EXR || st == ST_EXI) ? cur_of : 1'($urandom_range(0, 1));
    Eq = (st == ST_CMP) ? cur_eq : 1'($urandom_range(0, 1));
    OPCODE = (st == ST_DEC) ? cur_op : 6'($urandom_range(0, 63));
    {Ng, Zr, Gt, Lt} = 4'($urandom_range(0, 15));
  endtask

  task automatic run(input string tag, input int n);
    logic [17:0] e;
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      drive(e[17:14]);
      chk(tag, dut_vec, e);
      @(posedge clk); #1;
    end
  endtask

  task automatic run_all(input string tag);
    run(tag, exp_q.size());
  endtask

  function automatic logic [5:0] unknown_op();
    logic [5:0] p;
    do p = 6'($urandom_range(0, 63));
    while (p inside {6'h01, 6'h02, 6'h03, 6'h04, 6'h08, 6'h3F});
    return p;
  endfunction

  initial begin
    logic [17:0] e;
    logic [5:0] op;
    // Reset held for three edges; state sits in RST with only rst_out high.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_hold", dut_vec, rec(ST_RST, 0, 0, 0, 0, 3'b000, 0, 0, 0, 1, 0));
    end
    reset = 1'b0;
    @(posedge clk); #1;

    plan(6'h01, 0, 0); run_all("add");
    plan(6'h08, 1, 0); run_all("addi_ovf");
    plan(6'h03, 0, 0); run_all("and_after_ovf");
    plan(6'h04, 0, 1); run_all("beq_taken");
    plan(6'h04, 0, 0); run_all("beq_not_taken");
    plan(6'h2A, 0, 0); run_all("nop_2a");
    plan(6'h03, 1, 0); run_all("and_of_ignored");

    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 5))
        0: op = 6'h01;
        1: op = 6'h02;
        2: op = 6'h03;
        3: op = 6'h08;
        4: op = 6'h04;
        default: op = unknown_op();
      endcase
      plan(op, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
      run_all("rand");
    end

    // Reset landing on the write-back cycle of a SUB.
    plan(6'h02, 0, 0);
    run("sub_pre", exp_q.size() - 1);
    e = exp_q.pop_front();
    drive(e[17:14]);
    chk("sub_wb", dut_vec, e);
    reset = 1'b1;
    @(posedge clk); #1;
    ovf_m = 0;
    chk("rst_mid_wb", dut_vec, rec(ST_RST, 0, 0, 0, 0, 3'b000, 0, 0, 0, 1, 0));
    reset = 1'b0;
    @(posedge clk); #1;

    plan(6'h02, 1, 0); run_all("sub_ovf");
    plan(6'h3F, 0, 0); run_all("halt_entry");
    for (int i = 0; i < 20; i++) begin
      drive(4'd0);
      chk("halt_hold", dut_vec, rec(ST_HALT, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1));
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    ovf_m = 0;
    chk("halt_rst", dut_vec, rec(ST_RST, 0, 0, 0, 0, 3'b000, 0, 0, 0, 1, 0));
    reset = 1'b0;
    @(posedge clk); #1;
    plan(6'h01, 0, 0); run_all("add_after_halt");
    chk("final_fetch0", dut_vec, rec(ST_F0, 0, 0, 0, 0, 3'b100, 0, 0, 0, 0, 0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
